towers_collision_detector: RTL and testbench
============================================

// Module: towers_collision_detector
// PURPOSE
//  Consumer of the tower object generator's drawing stream. Samples the registered
//  towersDrawingRequest/offset outputs together with the player's drawing request.
//  Detects per-frame player/tower overlap inside a shrunken hitbox.
//  Reports at most one collision per frame and manages lives, an invulnerability grace
//  window and game-over. Sits between the object drawers and the game-control / score logic.
// PARAMETERS
//  INITIAL_LIVES   3   lives loaded at reset/restart (1..7)
//  GRACE_FRAMES    60  frames of invulnerability after a non-fatal hit (>=1)
//  HITBOX_MARGIN   2   pixels trimmed from each tower edge before overlap counts
//  OBJECT_WIDTH_X  28  tower width, must match the tower drawer
//  OBJECT_HEIGHT_Y 58  tower height, must match the tower drawer
// PORTS
//  clk                  in  1   system clock
//  resetN               in  1   async active-low reset
//  startOfFrame         in  1   one-cycle pulse per frame (vertical blank)
//  pause                in  1   level; freezes detection and counters
//  restart              in  1   one-cycle pulse; reinitialise game state
//  pixelX               in  11  current VGA pixel X (unregistered)
//  pixelY               in  11  current VGA pixel Y (unregistered)
//  playerDrawingRequest in  1   player pixel active, registered (1-cycle latency)
//  towersDrawingRequest in  1   tower pixel active, registered (1-cycle latency)
//  towerOffsetX         in  11  offset inside the drawn tower, valid with towersDrawingRequest
//  towerOffsetY         in  11  offset inside the drawn tower, valid with towersDrawingRequest
//  collisionPulse       out 1   one-cycle pulse on the startOfFrame closing a frame with a hit
//  hitX                 out 11  aligned pixel X of the first qualified overlap of the last hit frame
//  hitY                 out 11  aligned pixel Y of that overlap
//  lives                out 3   remaining lives
//  invulnerable         out 1   high while in GRACE
//  gameOver             out 1   high while in GAME_OVER
// BEHAVIOUR
//  Reset values: state=ARMED, lives=INITIAL_LIVES, every other output 0, frameHit=0, graceCnt=0.
//  Alignment: pixelX/Y are delayed 1 cycle internally (pxD/pyD) to match the registered requests.
//  qualify = player & towers & towerOffsetX in [M, W-M) & towerOffsetY in [M, H-M), M=HITBOX_MARGIN.
//    Offset compares are unsigned, 11 bit.
//  frameHit:
//    - set when qualify & state==ARMED & !pause & !frameHit;
//    - on that same cycle hitX<=pxD, hitY<=pyD (first overlap only, later overlaps ignored);
//    - on startOfFrame, cleared after evaluation; a qualify on that same cycle belongs to the new frame.
//  FSM, evaluated only on startOfFrame with !pause:
//    ARMED: if frameHit -> collisionPulse=1 this cycle, lives<=lives-1.
//      new lives==0 -> GAME_OVER; else -> GRACE, graceCnt<=GRACE_FRAMES-1.
//    GRACE: invulnerable=1 and qualify ignored.
//      graceCnt==0 -> ARMED; else graceCnt-1.
//    GAME_OVER: gameOver=1; lives, hitX/Y and state frozen until restart.
//  pause:
//    - no qualify sampling, no graceCnt change, no pulse;
//    - a frameHit already set is held across startOfFrame and reported after unpause.
//  restart (any state) -> ARMED, lives=INITIAL_LIVES, hitX/Y=0, frameHit=0, graceCnt=0.
//    restart wins over a coincident startOfFrame, and no pulse is issued.
//  lives never underflows below 0; collisionPulse is never high two cycles in a row.
//  Asynchronous reset mid-frame discards any pending frameHit.
// STRUCTURE
//  Package towers_game_pkg:
//    - typedef enum logic[1:0] {ARMED, GRACE, GAME_OVER} col_state_t;
//    - SCREEN_W=640, SCREEN_H=480;
//    - the shared OBJECT_WIDTH_X/OBJECT_HEIGHT_Y defaults.
//  Sub-module frame_timer:
//    - loadable down-counter advanced on startOfFrame & !pause;
//    - outputs done when it reaches 0.
//    - Used for graceCnt.
// TESTING
//  1. Overlap at pixel (100,200), offsets (5,5), in ARMED ->
//     next startOfFrame: collisionPulse=1 for one cycle, lives 3->2, hitX=100, hitY=200, invulnerable=1.
//  2. Overlaps in the same frame at (100,200) then (101,200) -> a single pulse; hitX stays 100.
//  3. Overlap with towerOffsetX=1 (inside margin) -> no pulse, lives unchanged.
//  4. Hit, then overlap every frame during GRACE ->
//     no pulse for 60 startOfFrames; ARMED again on the 60th; the next frame's overlap pulses.
//  5. Three hits spaced beyond the grace window ->
//     lives reaches 0, gameOver=1, further overlaps ignored; restart -> lives=3, gameOver=0.
//  6. Overlap, then pause over startOfFrame -> no pulse; unpause -> pulse on the next startOfFrame.
//     Reset asserted mid-frame after an overlap -> no pulse.

Source files
------------

// File: rtl/towers_game_pkg.sv
// Shared types and constants for the towers game datapath.
// Collision FSM states, screen size and tower geometry defaults.
package towers_game_pkg;

  typedef enum logic [1:0] {
    ARMED,
    GRACE,
    GAME_OVER
  } col_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int OBJECT_WIDTH_X  = 28;
  localparam int OBJECT_HEIGHT_Y = 58;

  // Half-open window test: lo <= v < hi, unsigned.
  function automatic logic in_window(
    input logic [10:0] v,
    input logic [10:0] lo,
    input logic [10:0] hi
  );
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/towers_collision_detector_frame_timer.sv
// frame_timer: loadable down-counter stepped once per frame.
// Ports: i_clear/i_load/i_tick controls, i_load_val, o_done when count is 0.
module frame_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/towers_collision_detector.sv
// Player/tower collision detector with lives, grace window and game-over.
// In: clk, resetN, startOfFrame, pause, restart, pixel, requests, offsets.
// Out: collisionPulse, hitX/hitY, lives, invulnerable, gameOver.
module towers_collision_detector
  import towers_game_pkg::*;
#(
  parameter int INITIAL_LIVES   = 3,
  parameter int GRACE_FRAMES    = 60,
  parameter int HITBOX_MARGIN   = 2,
  parameter int OBJECT_WIDTH_X  = towers_game_pkg::OBJECT_WIDTH_X,
  parameter int OBJECT_HEIGHT_Y = towers_game_pkg::OBJECT_HEIGHT_Y
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        pause,
  input  logic        restart,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        playerDrawingRequest,
  input  logic        towersDrawingRequest,
  input  logic [10:0] towerOffsetX,
  input  logic [10:0] towerOffsetY,
  output logic        collisionPulse,
  output logic [10:0] hitX,
  output logic [10:0] hitY,
  output logic [2:0]  lives,
  output logic        invulnerable,
  output logic        gameOver
);

  localparam logic [10:0] XLO =
    11'(HITBOX_MARGIN);
  localparam logic [10:0] XHI =
    11'(OBJECT_WIDTH_X - HITBOX_MARGIN);
  localparam logic [10:0] YLO =
    11'(HITBOX_MARGIN);
  localparam logic [10:0] YHI =
    11'(OBJECT_HEIGHT_Y - HITBOX_MARGIN);
  localparam logic [2:0]  LIVES0 =
    3'(INITIAL_LIVES);
  localparam logic [15:0] GRACE_LOAD =
    16'(GRACE_FRAMES - 1);

  col_state_t  r_state;
  col_state_t  w_state_nxt;
  logic [10:0] r_px_d;
  logic [10:0] r_py_d;
  logic [10:0] r_hit_x;
  logic [10:0] r_hit_y;
  logic [2:0]  r_lives;
  logic [2:0]  w_lives_nxt;
  logic        r_frame_hit;
  logic        w_qualify;
  logic        w_eval;
  logic        w_pulse;
  logic        w_load;
  logic        w_tick;
  logic        w_grace_done;
  logic        w_capture;

  // Requests arrive one cycle late; delay the pixel to match.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_px_d <= '0;
      r_py_d <= '0;
    end else begin
      r_px_d <= pixelX;
      r_py_d <= pixelY;
    end
  end

  assign w_qualify = playerDrawingRequest
                   & towersDrawingRequest
                   & in_window(towerOffsetX, XLO, XHI)
                   & in_window(towerOffsetY, YLO, YHI);

  // Frame boundary evaluation; restart overrides it.
  assign w_eval = startOfFrame & ~pause & ~restart;

  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_pulse     = 1'b0;
    w_load      = 1'b0;
    w_tick      = 1'b0;
    if (w_eval) begin
      unique case (r_state)
        ARMED: begin
          if (r_frame_hit) begin
            w_pulse     = 1'b1;
            w_lives_nxt = (r_lives != 3'd0) ?
                          3'(r_lives - 3'd1) : 3'd0;
            if (w_lives_nxt == 3'd0) begin
              w_state_nxt = GAME_OVER;
            end else begin
              w_state_nxt = GRACE;
              w_load      = 1'b1;
            end
          end
        end
        GRACE: begin
          if (w_grace_done) begin
            w_state_nxt = ARMED;
          end else begin
            w_tick = 1'b1;
          end
        end
        GAME_OVER: begin
          w_state_nxt = GAME_OVER;
        end
        default: begin
          w_state_nxt = ARMED;
        end
      endcase
    end
  end

  // On a frame boundary the overlap belongs to the new frame,
  // so it only counts if the new frame starts armed.
  always_comb begin
    w_capture = 1'b0;
    if (w_qualify && !pause) begin
      if (w_eval) begin
        w_capture = (w_state_nxt == ARMED);
      end else begin
        w_capture = (r_state == ARMED) && !r_frame_hit;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ARMED;
      r_lives     <= LIVES0;
      r_frame_hit <= 1'b0;
      r_hit_x     <= '0;
      r_hit_y     <= '0;
    end else if (restart) begin
      r_state     <= ARMED;
      r_lives     <= LIVES0;
      r_frame_hit <= 1'b0;
      r_hit_x     <= '0;
      r_hit_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lives <= w_lives_nxt;
      if (w_capture) begin
        r_frame_hit <= 1'b1;
        r_hit_x     <= r_px_d;
        r_hit_y     <= r_py_d;
      end else if (w_eval) begin
        r_frame_hit <= 1'b0;
      end
    end
  end

  frame_timer #(
    .W(16)
  ) u_grace (
    .clk        (clk),
    .resetN     (resetN),
    .i_clear    (restart),
    .i_load     (w_load),
    .i_load_val (GRACE_LOAD),
    .i_tick     (w_tick),
    .o_done     (w_grace_done)
  );

  assign collisionPulse = w_pulse;
  assign hitX           = r_hit_x;
  assign hitY           = r_hit_y;
  assign lives          = r_lives;
  assign invulnerable   = (r_state == GRACE);
  assign gameOver       = (r_state == GAME_OVER);

endmodule

// File: tb/tb_towers_collision_detector.sv
// Scoreboard bench for towers_collision_detector.
// Directed overlaps; monitor pops expected hits on collisionPulse.
module tb_towers_collision_detector;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        pause;
  logic        restart;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        playerDrawingRequest;
  logic        towersDrawingRequest;
  logic [10:0] towerOffsetX;
  logic [10:0] towerOffsetY;
  logic        collisionPulse;
  logic [10:0] hitX;
  logic [10:0] hitY;
  logic [2:0]  lives;
  logic        invulnerable;
  logic        gameOver;

  typedef struct {
    int x;
    int y;
    int l;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_pulse = 1'b0;

  always #5 clk = ~clk;

  towers_collision_detector dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (startOfFrame),
    .pause                (pause),
    .restart              (restart),
    .pixelX               (pixelX),
    .pixelY               (pixelY),
    .playerDrawingRequest (playerDrawingRequest),
    .towersDrawingRequest (towersDrawingRequest),
    .towerOffsetX         (towerOffsetX),
    .towerOffsetY         (towerOffsetY),
    .collisionPulse       (collisionPulse),
    .hitX                 (hitX),
    .hitY                 (hitY),
    .lives                (lives),
    .invulnerable         (invulnerable),
    .gameOver             (gameOver)
  );

  // Monitor: every pulse must match the oldest expected hit.
  always @(negedge clk) begin
    if (collisionPulse) begin
      n_vec++;
      if (prev_pulse) begin
        n_err++;
        $display("FAIL pulse_twice: actual 2 cycles, required 1");
      end
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: actual pulse hit=(%0d,%0d), required none",
                 hitX, hitY);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (int'(hitX) != e.x || int'(hitY) != e.y ||
            int'(lives) != e.l) begin
          n_err++;
          $display("FAIL pulse_data: actual (%0d,%0d,l%0d), required (%0d,%0d,l%0d)",
                   hitX, hitY, lives, e.x, e.y, e.l);
        end
      end
    end
    prev_pulse = collisionPulse;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
  endtask

  task automatic overlap(input int x, input int y,
                         input int ox, input int oy);
    pixelX = 11'(x);
    pixelY = 11'(y);
    step();
    pixelX = 11'(x + 1);
    playerDrawingRequest = 1'b1;
    towersDrawingRequest = 1'b1;
    towerOffsetX = 11'(ox);
    towerOffsetY = 11'(oy);
    step();
    playerDrawingRequest = 1'b0;
    towersDrawingRequest = 1'b0;
    step();
  endtask

  // Two consecutive overlapping pixels, x then x+1.
  task automatic overlap2(input int x, input int y,
                          input int ox, input int oy);
    pixelX = 11'(x);
    pixelY = 11'(y);
    step();
    pixelX = 11'(x + 1);
    playerDrawingRequest = 1'b1;
    towersDrawingRequest = 1'b1;
    towerOffsetX = 11'(ox);
    towerOffsetY = 11'(oy);
    step();
    pixelX = 11'(x + 2);
    towerOffsetX = 11'(ox + 1);
    step();
    playerDrawingRequest = 1'b0;
    towersDrawingRequest = 1'b0;
    step();
  endtask

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    pause = 1'b0;
    restart = 1'b0;
    pixelX = '0;
    pixelY = '0;
    playerDrawingRequest = 1'b0;
    towersDrawingRequest = 1'b0;
    towerOffsetX = '0;
    towerOffsetY = '0;
    repeat (3) step();
    chk("rst_lives", int'(lives), 3);
    chk("rst_pulse", int'(collisionPulse), 0);
    chk("rst_hitX", int'(hitX), 0);
    chk("rst_invul", int'(invulnerable), 0);
    chk("rst_gameover", int'(gameOver), 0);
    resetN = 1'b1;
    step();

    // Margin boundaries: all outside the trimmed hitbox.
    overlap(100, 200, 1, 5);
    sof();
    overlap(100, 200, 26, 5);
    sof();
    overlap(100, 200, 5, 1);
    sof();
    overlap(100, 200, 5, 56);
    sof();
    chk("margin_lives", int'(lives), 3);

    // First hit.
    q.push_back('{x: 100, y: 200, l: 3});
    overlap(100, 200, 5, 5);
    sof();
    chk("hit1_lives", int'(lives), 2);
    chk("hit1_invul", int'(invulnerable), 1);
    chk("hit1_hitX", int'(hitX), 100);
    chk("hit1_hitY", int'(hitY), 200);

    // Overlap every frame during grace: all ignored.
    for (int i = 0; i < 59; i++) begin
      overlap(150, 100, 10, 10);
      sof();
    end
    chk("grace59_invul", int'(invulnerable), 1);
    overlap(150, 100, 10, 10);
    sof();
    chk("grace60_armed", int'(invulnerable), 0);
    chk("grace_lives", int'(lives), 2);

    // Two overlaps in one frame at inner-edge offsets.
    q.push_back('{x: 300, y: 400, l: 2});
    overlap2(300, 400, 2, 55);
    sof();
    chk("hit2_lives", int'(lives), 1);
    chk("hit2_hitX", int'(hitX), 300);
    for (int i = 0; i < 60; i++) sof();
    chk("grace2_armed", int'(invulnerable), 0);

    // Pause holds a pending hit across a frame boundary.
    overlap(50, 60, 5, 5);
    pause = 1'b1;
    step();
    sof();
    chk("pause_lives", int'(lives), 1);
    pause = 1'b0;
    step();
    q.push_back('{x: 50, y: 60, l: 1});
    sof();
    chk("hit3_lives", int'(lives), 0);
    chk("hit3_gameover", int'(gameOver), 1);

    // Game over ignores overlaps.
    overlap(10, 20, 5, 5);
    sof();
    chk("go_lives", int'(lives), 0);
    chk("go_hitX", int'(hitX), 50);

    // Restart wins over a coincident frame start.
    restart = 1'b1;
    startOfFrame = 1'b1;
    step();
    restart = 1'b0;
    startOfFrame = 1'b0;
    step();
    chk("rs_lives", int'(lives), 3);
    chk("rs_gameover", int'(gameOver), 0);
    chk("rs_hitX", int'(hitX), 0);

    // Async reset mid-frame drops a pending hit.
    overlap(70, 80, 5, 5);
    #2;
    resetN = 1'b0;
    #2;
    resetN = 1'b1;
    step();
    sof();
    chk("rstmid_lives", int'(lives), 3);
    chk("rstmid_hitX", int'(hitX), 0);

    // Hit after restart pulses normally.
    q.push_back('{x: 33, y: 44, l: 3});
    overlap(33, 44, 20, 30);
    sof();
    chk("hit4_lives", int'(lives), 2);

    repeat (3) step();
    chk("pending_hits", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
